// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty core and its program-side instruction issuer.
package bitty_pkg;

    localparam int INSTR_W = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT_MEM = 3'd2,
        ISSUE    = 3'd3,
        EXEC     = 3'd4,
        DONE     = 3'd5
    } fetch_state_t;

endpackage

// File: rtl/bitty_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count would reach TIMEOUT.
module bitty_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    // Combinational so the owner can react in the same cycle the limit is hit.
    assign expired = enable && (cnt >= CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bitty_fetch.sv
// Program-side instruction issuer for the bitty core: fetches from a
// synchronous-read memory, pulses run with d_instr, and waits for done.
module bitty_fetch #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = bitty_pkg::INSTR_W,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W:0]    prog_len,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               run,
    output logic [INSTR_W-1:0] d_instr,
    input  logic               done,
    output logic               busy,
    output logic               finished,
    output logic               error,
    output logic [ADDR_W-1:0]  pc,
    output logic [2:0]         dbg_state
);

    import bitty_pkg::*;

    // Handshake: run is a one-cycle strobe meaning d_instr is valid; the core
    // answers with done at any later cycle; done is only honoured in EXEC.

    fetch_state_t state, state_next;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] pc_plus_ext;
    logic            accept;
    logic            pc_inc;
    logic            set_err;
    logic            wd_clear;
    logic            wd_en;
    logic            wd_expired;

    assign pc_plus_ext = {1'b0, pc} + (ADDR_W + 1)'(1);
    assign mem_addr    = pc;
    assign busy        = (state != IDLE);
    assign dbg_state   = state;

    bitty_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_en),
        .expired (wd_expired)
    );

    always_comb begin
        state_next = state;
        mem_rd_en  = 1'b0;
        run        = 1'b0;
        finished   = 1'b0;
        accept     = 1'b0;
        pc_inc     = 1'b0;
        set_err    = 1'b0;
        wd_clear   = 1'b0;
        wd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (prog_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                mem_rd_en  = 1'b1;
                state_next = WAIT_MEM;
            end
            WAIT_MEM: state_next = ISSUE;
            ISSUE: begin
                run        = 1'b1;
                wd_clear   = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                wd_en = 1'b1;
                if (done) begin
                    pc_inc     = 1'b1;
                    state_next = (pc_plus_ext == len_q) ? DONE : FETCH;
                end else if (wd_expired) begin
                    set_err    = 1'b1;
                    state_next = IDLE;
                end
            end
            DONE: begin
                finished   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Abort overrides everything else and suppresses every side effect.
        if (abort && (state != IDLE)) begin
            state_next = IDLE;
            mem_rd_en  = 1'b0;
            run        = 1'b0;
            finished   = 1'b0;
            pc_inc     = 1'b0;
            set_err    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pc      <= '0;
            d_instr <= '0;
            error   <= 1'b0;
            len_q   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                pc    <= '0;
                len_q <= prog_len;
                error <= 1'b0;
            end else if (pc_inc) begin
                pc <= pc + ADDR_W'(1);
            end
            if (set_err) begin
                error <= 1'b1;
            end
            if ((state == WAIT_MEM) && !abort) begin
                d_instr <= mem_rdata;
            end
        end
    end

endmodule
